// File: rtl/pcpi_result_serializer_pkg.sv
`default_nettype none
// ==== pcpi_ser_pkg: widths and FSM state type shared by the serialiser and deserialiser ====
// ==== Rev 1.0 ==============================================================================
package pcpi_ser_pkg;

  localparam int WORD_W  = 32;
  localparam int NIB_W   = 4;
  localparam int NIBBLES = WORD_W / NIB_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/pcpi_result_serializer_if.sv
`default_nettype none
// ==== pcpi_result_serializer_if: PCPI result strobe in, four-phase nibble link out ====
// ==== Rev 1.0 ========================================================================
interface pcpi_result_serializer_if #(
  parameter int WORD_W = pcpi_ser_pkg::WORD_W,
  parameter int NIB_W  = pcpi_ser_pkg::NIB_W
);

  logic              pcpi_ready;
  logic              pcpi_wr;
  logic [WORD_W-1:0] pcpi_rd;
  logic              nib_ack;
  logic [NIB_W-1:0]  nib_out;
  logic              nib_valid;
  logic              busy;
  logic              word_done;
  logic              overrun;

  modport master (
    output pcpi_ready, pcpi_wr, pcpi_rd, nib_ack,
    input  nib_out, nib_valid, busy, word_done, overrun
  );

  modport slave (
    input  pcpi_ready, pcpi_wr, pcpi_rd, nib_ack,
    output nib_out, nib_valid, busy, word_done, overrun
  );

endinterface
`default_nettype wire

// File: rtl/pcpi_result_serializer.sv
`default_nettype none
// ==== pcpi_result_serializer: returns PCPI result words LSB-nibble first over a 4-phase link ====
// ==== Rev 1.0 ===================================================================================
module pcpi_result_serializer #(
  parameter int WORD_W  = pcpi_ser_pkg::WORD_W,
  parameter int NIB_W   = pcpi_ser_pkg::NIB_W,
  parameter int NIBBLES = WORD_W / NIB_W
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  pcpi_result_serializer_if.slave bus
);

  import pcpi_ser_pkg::*;

  localparam int                 c_CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_NIB = c_CNT_W'(NIBBLES - 1);

  ser_state_e                       r_state;
  ser_state_e                       w_state_nxt;
  logic [c_CNT_W-1:0]               r_cnt;
  logic [c_CNT_W-1:0]               w_cnt_nxt;
  logic [WORD_W-1:0]                r_word;
  logic [WORD_W-1:0]                w_word_nxt;
  logic [WORD_W-1:0]                r_hold;
  logic [WORD_W-1:0]                w_hold_nxt;
  logic                             r_hold_full;
  logic                             w_hold_full_nxt;
  logic                             r_overrun;
  logic                             w_overrun_nxt;
  logic                             w_accept;
  logic [NIBBLES-1:0][NIB_W-1:0]    w_nibs;

  assign w_accept = bus.pcpi_ready & bus.pcpi_wr;
  assign w_nibs   = r_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_word      <= w_word_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_word_nxt      = r_word;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_overrun_nxt   = r_overrun;

    unique case (r_state)
      S_IDLE: begin
        // A waiting word always goes first; a simultaneous arrival refills the slot it vacates.
        if (r_hold_full) begin
          w_word_nxt  = r_hold;
          w_cnt_nxt   = '0;
          w_state_nxt = S_PRESENT;
          if (w_accept) begin
            w_hold_nxt = bus.pcpi_rd;
          end else begin
            w_hold_full_nxt = 1'b0;
          end
        end else if (w_accept) begin
          w_word_nxt  = bus.pcpi_rd;
          w_cnt_nxt   = '0;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.nib_ack) begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!bus.nib_ack) begin
          if (r_cnt < c_LAST_NIB) begin
            w_cnt_nxt   = r_cnt + c_CNT_W'(1);
            w_state_nxt = S_PRESENT;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if ((r_state != S_IDLE) && w_accept) begin
      if (!r_hold_full) begin
        w_hold_nxt      = bus.pcpi_rd;
        w_hold_full_nxt = 1'b1;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    bus.nib_out   = '0;
    bus.nib_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.word_done = 1'b0;
    bus.overrun   = r_overrun;

    unique case (r_state)
      S_PRESENT: begin
        bus.nib_out   = w_nibs[r_cnt];
        bus.nib_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      S_RELEASE: begin
        bus.nib_out = w_nibs[r_cnt];
        bus.busy    = 1'b1;
      end
      S_DONE: begin
        bus.word_done = 1'b1;
      end
      default: begin
        bus.nib_out = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/pcpi_result_serializer.md
PCPI_RESULT_SERIALIZER -- requirements
Module: pcpi_result_serializer

Interface
REQ-001 Parameters SHALL be: WORD_W, default 32, result width; NIB_W, default 4, pin nibble width; NIBBLES = WORD_W/NIB_W, derived, default 8.
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 pcpi_ready  in  1  coprocessor result strobe, one cycle.
REQ-005 pcpi_wr  in  1  qualifies pcpi_rd as a result to return.
REQ-006 pcpi_rd  in  WORD_W  coprocessor result word.
REQ-007 nib_ack  in  1  host acknowledge for the four-phase handshake.
REQ-008 nib_out  out  NIB_W  current result nibble.
REQ-009 nib_valid  out  1  nib_out stable and presented to the host.
REQ-010 busy  out  1  a word is being serialised.
REQ-011 word_done  out  1  one-cycle pulse after the last nibble is released.
REQ-012 overrun  out  1  sticky: a result was dropped.

Function
REQ-013 A result SHALL be accepted only in a cycle with pcpi_ready=1 and pcpi_wr=1; pcpi_ready with pcpi_wr=0 SHALL be ignored.
REQ-014 FSM states SHALL be: IDLE, PRESENT, RELEASE, DONE.
REQ-015 IDLE: on an accepted result or a full hold buffer -> load shift word, nibble count 0, go to PRESENT next cycle; busy=1 from that cycle.
REQ-016 PRESENT: nib_valid=1 and nib_out=word[NIB_W*cnt +: NIB_W]; on nib_ack=1 -> RELEASE.
REQ-017 RELEASE: nib_valid=0; on nib_ack=0 -> PRESENT with cnt+1 if cnt<NIBBLES-1, else -> DONE.
REQ-018 DONE: word_done=1 for exactly one cycle; busy=0 in DONE; -> IDLE.
REQ-019 Nibbles SHALL be sent least-significant first; count SHALL NOT wrap within a word.
REQ-020 nib_out SHALL hold its value in RELEASE and SHALL be 0 in IDLE and DONE.
REQ-021 Latency from the accepting cycle to the first nib_valid=1 SHALL be exactly 1 cycle.
REQ-022 nib_ack already high when PRESENT is entered SHALL complete the handshake immediately (no edge detection).
REQ-023 A one-entry hold buffer SHALL capture an accepted result that arrives while busy=1 or in DONE.
REQ-024 In IDLE, a full hold buffer SHALL be loaded before any new result; a new result in the same cycle SHALL go into the freed buffer.
REQ-025 An accepted result that arrives while the hold buffer is full and not draining SHALL be dropped and set overrun=1.
REQ-026 overrun SHALL clear only on reset.
REQ-027 nib_ack SHALL be ignored in IDLE and DONE.

Reset
REQ-028 With rst_n=0 at a clock edge: state=IDLE, cnt=0, hold buffer empty, shift word=0.
REQ-029 Outputs in reset SHALL be: nib_out=0, nib_valid=0, busy=0, word_done=0, overrun=0.
REQ-030 Reset mid-word SHALL abandon the word and the hold buffer with no word_done pulse.

Structure
REQ-031 Package pcpi_ser_pkg SHALL hold WORD_W, NIB_W, NIBBLES and the state enum, shared with the upstream nibble deserialiser.
REQ-032 No sub-module is required; the hold buffer and FSM SHALL stay inline.

Verification
REQ-033 Single word: pcpi_rd=32'h8765_4321 with wr=1; host acks each nibble -> nib_out sequence 1,2,3,4,5,6,7,8, then one word_done pulse, then busy=0.
REQ-034 Ignore: pcpi_ready=1, pcpi_wr=0, rd=32'hFFFF_FFFF -> nib_valid stays 0, busy stays 0.
REQ-035 Back-to-back: 32'h0000_00A5 then 32'h1111_1111 during nibble 2 -> second word is serialised after word_done, overrun=0.
REQ-036 Overrun: three results while the host withholds ack -> first two serialised in order, third lost, overrun=1 until reset.
REQ-037 Stuck ack: nib_ack held high -> handshake stalls in RELEASE with nib_valid=0 and nib_out held; releasing ack resumes at the next nibble.
REQ-038 Mid-word reset: rst_n=0 during nibble 4 -> all outputs 0 next cycle, no word_done, held word discarded.
